// File: rtl/down_timer_pkg.sv
// down_timer_pkg: shared state encoding for the down_timer FSM
// Contents: state_t (IDLE=0, RUN=1, PAUSE=2, DONE=3)
package down_timer_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/down_timer.sv
// down_timer: loadable down-counter with pause, auto-reload and terminal-count pulse
// Ports: clk, rst (async, active-high), load/load_val (set count and reload value),
//        start (IDLE/DONE only), pause (level hold), auto_reload (sampled at count==1),
//        count (registered value), tc (one-cycle terminal pulse), busy (RUN/PAUSE), done (DONE)
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);
    state_t           state, state_n;
    logic [WIDTH-1:0] reload_reg, reload_n, count_n;
    logic             tc_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            tc         <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            reload_reg <= reload_n;
            tc         <= tc_n;
        end
    end

    always_comb begin
        state_n  = state;
        count_n  = count;
        reload_n = reload_reg;
        tc_n     = 1'b0;
        if (load) begin
            count_n  = load_val;
            reload_n = load_val;
            state_n  = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // a zero reload value terminates immediately
                        state_n = (reload_reg == '0) ? DONE : RUN;
                        count_n = reload_reg;
                        tc_n    = (reload_reg == '0);
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_n = PAUSE;
                    end else if (count > WIDTH'(1)) begin
                        count_n = count - WIDTH'(1);
                    end else begin
                        tc_n    = 1'b1;
                        count_n = auto_reload ? reload_reg : '0;
                        state_n = auto_reload ? RUN : DONE;
                    end
                end
                PAUSE: begin
                    // resume without decrementing on the release edge
                    if (!pause) state_n = RUN;
                end
            endcase
        end
    end

    assign busy = (state == RUN) || (state == PAUSE);
    assign done = (state == DONE);
endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: randomized and directed self-checking bench for down_timer
module tb_down_timer;
    logic       clk, rst, load, start, pause, auto_reload;
    logic [3:0] load_val, count;
    logic       tc, busy, done;
    int         errors = 0, checks = 0, tc_seen = 0;
    int         m_count, m_reload;
    bit         m_active, m_hold, m_fin, m_tc;

    down_timer #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
        .pause(pause), .auto_reload(auto_reload), .count(count), .tc(tc),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_reload = 0; m_active = 0; m_hold = 0; m_fin = 0; m_tc = 0;
    endtask

    // behavioural reference: one clock edge worth of timer behaviour
    task automatic model_step();
        m_tc = 0;
        if (load) begin
            m_count = int'(load_val); m_reload = int'(load_val);
            m_active = 0; m_hold = 0; m_fin = 0;
        end else if (!m_active) begin
            if (start) begin
                m_count = m_reload;
                if (m_reload == 0) begin m_fin = 1; m_tc = 1; end
                else begin m_active = 1; m_fin = 0; end
            end
        end else if (m_hold) begin
            if (!pause) m_hold = 0;
        end else if (pause) begin
            m_hold = 1;
        end else if (m_count > 1) begin
            m_count--;
        end else begin
            m_tc = 1;
            if (auto_reload) m_count = m_reload;
            else begin m_count = 0; m_active = 0; m_fin = 1; end
        end
    endtask

    task automatic compare(input string tag);
        chk({tag, ".count"}, int'(count), m_count);
        chk({tag, ".tc"}, int'(tc), int'(m_tc));
        chk({tag, ".busy"}, int'(busy), int'(m_active));
        chk({tag, ".done"}, int'(done), int'(m_fin && !m_active));
    endtask

    task automatic cyc(input string tag, input bit l, input int lv, input bit s, input bit p, input bit a);
        load = l; load_val = 4'(lv); start = s; pause = p; auto_reload = a;
        @(posedge clk);
        #1;
        model_step();
        compare(tag);
        if (tc) tc_seen++;
    endtask

    // pulse rst between clock edges and check the outputs clear without a clock
    task automatic areset(input string tag);
        #2 rst = 1'b1;
        #1 model_reset();
        compare(tag);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 0; load_val = 0; start = 0; pause = 0; auto_reload = 0;
        model_reset();
        #1 compare("reset");
        #12 rst = 1'b0;

        cyc("r28", 1, 5, 0, 0, 0);
        cyc("r28", 0, 0, 1, 0, 0);
        repeat (7) cyc("r28", 0, 0, 0, 0, 0);

        cyc("r29", 1, 3, 0, 0, 1);
        cyc("r29", 0, 0, 1, 0, 1);
        repeat (10) cyc("r29", 0, 0, 0, 0, 1);

        tc_seen = 0;
        cyc("r30", 1, 6, 0, 0, 0);
        cyc("r30", 0, 0, 1, 0, 0);
        repeat (2) cyc("r30", 0, 0, 0, 0, 0);
        chk("r30.at4", int'(count), 4);
        repeat (3) cyc("r30", 0, 0, 0, 1, 0);
        repeat (7) cyc("r30", 0, 0, 0, 0, 0);
        chk("r30.one_tc", tc_seen, 1);

        cyc("r31", 1, 0, 0, 0, 0);
        cyc("r31", 0, 0, 1, 0, 0);
        cyc("r31", 0, 0, 0, 0, 0);
        cyc("r31", 1, 2, 0, 0, 0);
        cyc("r31", 0, 0, 1, 0, 0);
        repeat (3) cyc("r31", 0, 0, 0, 0, 0);

        tc_seen = 0;
        cyc("r32", 1, 9, 0, 0, 0);
        cyc("r32", 0, 0, 1, 0, 0);
        repeat (4) cyc("r32", 0, 0, 0, 0, 0);
        chk("r32.at5", int'(count), 5);
        areset("r32.rst");
        cyc("r32", 0, 0, 0, 0, 0);
        chk("r32.no_tc", tc_seen, 0);
        cyc("r32", 0, 0, 1, 0, 0);
        cyc("r32", 0, 0, 0, 0, 0);

        cyc("r33", 1, 6, 0, 0, 0);
        cyc("r33", 0, 0, 1, 0, 0);
        repeat (2) cyc("r33", 0, 0, 0, 0, 0);
        cyc("r33", 1, 7, 1, 0, 0);
        cyc("r33", 0, 0, 0, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            cyc("rand", $urandom_range(15) == 0, int'($urandom_range(15)),
                $urandom_range(3) == 0, $urandom_range(4) == 0, $urandom_range(1) == 1);
            if ($urandom_range(99) == 0) areset("rand.rst");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
